// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction sequencer and its decoder.
// The instruction classification rule lives here so the capture path and the decoder agree on it.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_MOV_IMM = 3'd1,
    S_GET_A   = 3'd2,
    S_GET_B   = 3'd3,
    S_ALU     = 3'd4,
    S_CMP     = 3'd5,
    S_WR_REG  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } iclass_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  function automatic iclass_t classify(input logic [4:0] opc_op);
    iclass_t c;
    c = CLS_ILLEGAL;
    case (opc_op)
      {OPC_MOV, 2'b10}:  c = CLS_MOV_IMM;
      {OPC_MOV, 2'b00}:  c = CLS_MOV_REG;
      {OPC_ALU, ALU_ADD}: c = CLS_ADD;
      {OPC_ALU, ALU_CMP}: c = CLS_CMP;
      {OPC_ALU, ALU_AND}: c = CLS_AND;
      {OPC_ALU, ALU_MVN}: c = CLS_MVN;
      default:           c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational field decode of the held instruction register: register index mux,
// immediate sign extension, ALU op selection and instruction class.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       i_ir,
  input  logic [2:0]        i_nsel,
  output logic [2:0]        o_readnum,
  output logic [2:0]        o_writenum,
  output logic [DATA_W-1:0] o_sximm8,
  output logic [1:0]        o_aluop,
  output logic [1:0]        o_sh,
  output logic              o_legal,
  output iclass_t           o_iclass
);

  logic [2:0] w_regnum;

  always_comb begin
    w_regnum = 3'd0;
    case (i_nsel)
      NSEL_RN: w_regnum = i_ir[10:8];
      NSEL_RD: w_regnum = i_ir[7:5];
      NSEL_RM: w_regnum = i_ir[2:0];
      default: w_regnum = 3'd0;
    endcase
  end

  assign o_readnum  = w_regnum;
  assign o_writenum = w_regnum;
  assign o_sximm8   = {{(DATA_W-8){i_ir[7]}}, i_ir[7:0]};
  // MOV always routes through the adder; ALU instructions carry their op in IR[12:11]
  assign o_aluop    = (i_ir[15:13] == OPC_MOV) ? ALU_ADD : i_ir[12:11];
  assign o_sh       = i_ir[4:3];
  assign o_iclass   = classify(i_ir[15:11]);
  assign o_legal    = (o_iclass != CLS_ILLEGAL);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: captures an instruction in WAIT and steps the datapath strobes
// through read / ALU / write-back as a Moore function of state and the held IR.
//
// state     | meaning
// S_WAIT    | idle, w=1, samples s and in
// S_MOV_IMM | write sign-extended imm8 into Rn
// S_GET_A   | load A from Rn
// S_GET_B   | load B from Rm through the shifter
// S_ALU     | load C with the ALU result
// S_CMP     | load status flags from a subtract, no write
// S_WR_REG  | write C into Rd
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [15:0]       in,
  output logic              w,
  output logic              illegal,
  output logic [2:0]        nsel,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic              write,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm8
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic        r_illegal;
  iclass_t     w_in_class;
  iclass_t     w_ir_class;
  logic        w_ir_legal;
  logic [1:0]  w_sh;
  logic        w_accept;

  assign w_in_class = classify(in[15:11]);
  assign w_accept   = (r_state == S_WAIT) && s && (w_in_class != CLS_ILLEGAL);

  instr_decoder #(.DATA_W(DATA_W)) u_dec (
    .i_ir       (r_ir),
    .i_nsel     (nsel),
    .o_readnum  (readnum),
    .o_writenum (writenum),
    .o_sximm8   (sximm8),
    .o_aluop    (ALUop),
    .o_sh       (w_sh),
    .o_legal    (w_ir_legal),
    .o_iclass   (w_ir_class)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_WAIT;
      r_ir      <= 16'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= (r_state == S_WAIT) && s && (w_in_class == CLS_ILLEGAL);
      if (w_accept) r_ir <= in;
    end
  end

  assign illegal = r_illegal;
  assign bsel    = 1'b0;

  always_comb begin
    w_next = S_WAIT;
    w      = 1'b0;
    nsel   = NSEL_NONE;
    loada  = 1'b0;
    loadb  = 1'b0;
    loadc  = 1'b0;
    loads  = 1'b0;
    asel   = 1'b0;
    vsel   = VSEL_C;
    write  = 1'b0;
    shift  = 2'b00;
    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) begin
          case (w_in_class)
            CLS_MOV_IMM:         w_next = S_MOV_IMM;
            CLS_MOV_REG, CLS_MVN: w_next = S_GET_B;
            CLS_ADD, CLS_CMP, CLS_AND: w_next = S_GET_A;
            default:             w_next = S_WAIT;
          endcase
        end
      end
      S_MOV_IMM: begin
        nsel   = NSEL_RN;
        vsel   = VSEL_IMM;
        write  = 1'b1;
        w_next = S_WAIT;
      end
      S_GET_A: begin
        nsel   = NSEL_RN;
        loada  = 1'b1;
        w_next = S_GET_B;
      end
      S_GET_B: begin
        nsel   = NSEL_RM;
        loadb  = 1'b1;
        shift  = w_sh;
        w_next = (w_ir_class == CLS_CMP) ? S_CMP : S_ALU;
      end
      S_ALU: begin
        loadc  = 1'b1;
        asel   = (w_ir_class == CLS_MOV_REG) || (w_ir_class == CLS_MVN);
        shift  = w_sh;
        w_next = S_WR_REG;
      end
      S_CMP: begin
        loads  = 1'b1;
        w_next = S_WAIT;
      end
      S_WR_REG: begin
        nsel   = NSEL_RD;
        vsel   = VSEL_C;
        write  = 1'b1;
        w_next = S_WAIT;
      end
      default: w_next = S_WAIT;
    endcase
    // a busy state can only be reached with a legal IR; fall back to idle if that ever breaks
    if ((r_state != S_WAIT) && !w_ir_legal) w_next = S_WAIT;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: a micro-op queue model of each accepted instruction is compared
// against the DUT every cycle, plus directed literal checks of the documented scenarios.
module tb_instr_sequencer;

  typedef struct packed {
    logic [2:0] nsel;
    logic [2:0] idx;
    logic       la, lb, lc, ls, asel;
    logic [1:0] vsel;
    logic       wr;
    logic [1:0] sh;
  } step_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s = 1'b0;
  logic [15:0] in_r = 16'd0;
  logic        w, illegal, loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0]  nsel, readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8;

  instr_sequencer #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .s(s), .in(in_r),
    .w(w), .illegal(illegal), .nsel(nsel), .readnum(readnum), .writenum(writenum),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write), .shift(shift),
    .ALUop(ALUop), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  step_t       m_q[$];
  logic [15:0] m_ir = 16'd0;
  logic        m_ill = 1'b0;

  function automatic step_t mk(input logic [2:0] ns, input logic [2:0] ix, input logic la,
                               input logic lb, input logic lc, input logic ls, input logic as,
                               input logic [1:0] vs, input logic wr, input logic [1:0] sh);
    step_t t;
    t.nsel = ns; t.idx = ix; t.la = la; t.lb = lb; t.lc = lc; t.ls = ls;
    t.asel = as; t.vsel = vs; t.wr = wr; t.sh = sh;
    return t;
  endfunction

  // Expands an instruction into its micro-op list; returns 0 if it is not part of the ISA.
  function automatic bit model_accept(input logic [15:0] x);
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    step_t rd_a, rd_b, wb;
    rn = x[10:8]; rd = x[7:5]; rm = x[2:0]; sh = x[4:3];
    rd_a = mk(3'b100, rn, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    rd_b = mk(3'b001, rm, 0, 1, 0, 0, 0, 2'b00, 0, sh);
    wb   = mk(3'b010, rd, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00);
    if (x[15:13] == 3'b110 && x[12:11] == 2'b10) begin
      m_q.push_back(mk(3'b100, rn, 0, 0, 0, 0, 0, 2'b10, 1, 2'b00));
      return 1;
    end
    if (x[15:13] == 3'b110 && x[12:11] == 2'b00) begin
      m_q.push_back(rd_b);
      m_q.push_back(mk(3'b000, 3'd0, 0, 0, 1, 0, 1, 2'b00, 0, sh));
      m_q.push_back(wb);
      return 1;
    end
    if (x[15:13] == 3'b101) begin
      if (x[12:11] == 2'b11) begin
        m_q.push_back(rd_b);
        m_q.push_back(mk(3'b000, 3'd0, 0, 0, 1, 0, 1, 2'b00, 0, sh));
        m_q.push_back(wb);
      end else if (x[12:11] == 2'b01) begin
        m_q.push_back(rd_a);
        m_q.push_back(rd_b);
        m_q.push_back(mk(3'b000, 3'd0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00));
      end else begin
        m_q.push_back(rd_a);
        m_q.push_back(rd_b);
        m_q.push_back(mk(3'b000, 3'd0, 0, 0, 1, 0, 0, 2'b00, 0, sh));
        m_q.push_back(wb);
      end
      return 1;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_ir  = 16'd0;
      m_ill = 1'b0;
    end else if (m_q.size() != 0) begin
      void'(m_q.pop_front());
      m_ill = 1'b0;
    end else if (s) begin
      if (model_accept(in_r)) begin
        m_ir  = in_r;
        m_ill = 1'b0;
      end else begin
        m_ill = 1'b1;
      end
    end else begin
      m_ill = 1'b0;
    end
  end

  // ---------------- compare process + observation log ----------------
  int         n_write = 0, n_illegal = 0, n_strobe = 0;
  logic [2:0] obs_wnum, obs_a_idx, obs_b_idx;
  logic [1:0] obs_vsel, obs_b_sh, obs_c_aluop, obs_s_aluop;
  logic       obs_c_asel;

  always @(negedge clk) begin
    step_t      e;
    logic       ew;
    logic [1:0] ealu;
    if (m_q.size() != 0) begin
      e  = m_q[0];
      ew = 1'b0;
    end else begin
      e  = '0;
      ew = 1'b1;
    end
    ealu = (m_ir[15:13] == 3'b110) ? 2'b00 : m_ir[12:11];
    chk("ctrl", {17'd0, w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, shift},
        {17'd0, ew, e.nsel, e.la, e.lb, e.lc, e.ls, e.asel, 1'b0, e.vsel, e.wr, e.sh});
    chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
    chk("aluop", {30'd0, ALUop}, {30'd0, ealu});
    chk("sximm8", {16'd0, sximm8}, {16'd0, {{8{m_ir[7]}}, m_ir[7:0]}});
    if (e.nsel != 3'b000) begin
      chk("readnum", {29'd0, readnum}, {29'd0, e.idx});
      chk("writenum", {29'd0, writenum}, {29'd0, e.idx});
    end
    if (write) begin n_write++; obs_wnum = writenum; obs_vsel = vsel; end
    if (illegal) n_illegal++;
    if (loada || loadb || loadc || loads || write) n_strobe++;
    if (loada) obs_a_idx = readnum;
    if (loadb) begin obs_b_idx = readnum; obs_b_sh = shift; end
    if (loadc) begin obs_c_asel = asel; obs_c_aluop = ALUop; end
    if (loads) obs_s_aluop = ALUop;
  end

  // ---------------- directed + random stimulus ----------------
  task automatic run_instr(input logic [15:0] instr, input int exp_busy, input string nm);
    int cnt, budget;
    @(negedge clk); #1; s = 1'b1; in_r = instr;
    @(negedge clk); #1; s = 1'b0; in_r = 16'($urandom);
    cnt = 0; budget = 0;
    while (w == 1'b0 && budget < 10) begin
      cnt++; budget++;
      @(negedge clk); #1;
    end
    chk(nm, cnt, exp_busy);
  endtask

  function automatic logic [15:0] gen_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2, 3, 4, 5: r[15:13] = 3'b101;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    int wb, ib, sb;
    #1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_w", {31'd0, w}, 32'd1);
    chk("rst_nsel_write", {28'd0, nsel, write}, 32'd0);
    reset = 1'b1;

    wb = n_write;
    run_instr(16'hD0FB, 1, "mov_imm_busy");
    chk("mov_imm_writes", n_write - wb, 1);
    chk("mov_imm_wnum", {29'd0, obs_wnum}, 32'd0);
    chk("mov_imm_vsel", {30'd0, obs_vsel}, 32'd2);
    chk("mov_imm_sximm8", {16'd0, sximm8}, 32'h0000FFFB);

    wb = n_write;
    run_instr(16'hA148, 4, "add_busy");
    chk("add_writes", n_write - wb, 1);
    chk("add_a_idx", {29'd0, obs_a_idx}, 32'd1);
    chk("add_b_idx_sh", {27'd0, obs_b_idx, obs_b_sh}, {27'd0, 3'd0, 2'b01});
    chk("add_c_asel_alu", {29'd0, obs_c_asel, obs_c_aluop}, 32'd0);
    chk("add_wnum_vsel", {27'd0, obs_wnum, obs_vsel}, {27'd0, 3'd2, 2'b00});

    wb = n_write;
    run_instr(16'hAB04, 3, "cmp_busy");
    chk("cmp_writes", n_write - wb, 0);
    chk("cmp_s_aluop", {30'd0, obs_s_aluop}, 32'd1);
    chk("cmp_ab_idx", {26'd0, obs_a_idx, obs_b_idx}, {26'd0, 3'd3, 3'd4});

    wb = n_write;
    run_instr(16'hB8E1, 3, "mvn_busy");
    chk("mvn_writes", n_write - wb, 1);
    chk("mvn_b_idx", {29'd0, obs_b_idx}, 32'd1);
    chk("mvn_c_asel_alu", {29'd0, obs_c_asel, obs_c_aluop}, {29'd0, 1'b1, 2'b11});
    chk("mvn_wnum", {29'd0, obs_wnum}, 32'd7);

    ib = n_illegal; sb = n_strobe;
    run_instr(16'hE000, 0, "ill_e000_busy");
    chk("ill_e000_pulse", n_illegal - ib, 1);
    ib = n_illegal;
    run_instr(16'hC800, 0, "ill_c800_busy");
    chk("ill_c800_pulse", n_illegal - ib, 1);
    chk("ill_no_strobe", n_strobe - sb, 0);

    wb = n_write;
    @(negedge clk); #1; s = 1'b1; in_r = 16'hA148;
    @(negedge clk); #1; s = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("pre_rst_loadc", {31'd0, loadc}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_strobes", {27'd0, loada, loadb, loadc, loads, write}, 32'd0);
    chk("rst_mid_w", {31'd0, w}, 32'd1);
    @(negedge clk); #1; reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_mid_no_write", n_write - wb, 0);

    wb = n_write;
    s = 1'b1; in_r = 16'hD0FB;
    repeat (10) begin
      @(negedge clk); #1;
      in_r = {5'b11010, 11'($urandom)};
    end
    s = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("s_held_writes", n_write - wb, 5);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      s     = ($urandom_range(0, 3) != 0);
      in_r  = gen_instr();
      reset = ($urandom_range(0, 99) != 0);
    end
    @(negedge clk); #1; reset = 1'b1; s = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
